// File: rtl/pe_pkg.sv
// Shared widths and FSM encoding for the global-buffer stream feeder.
package pe_pkg;

  localparam int unsigned PE_DATA_WIDTH = 16;
  localparam int unsigned PE_ADDR_WIDTH = 8;
  localparam int unsigned PE_PARA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/feeder_skid_buf.sv
// Two-entry FIFO-ordered skid buffer between the RAM read port and the PE input.
module feeder_skid_buf
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      // Push into a full buffer is only legal together with a pop, so the
      // slot being overwritten is the head that leaves this cycle.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

  always_comb begin
    head = '0;
    if (!empty) begin
      head = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/glb_stream_feeder.sv
// Streams cmd_len words from the global buffer RAM into a PE input FIFO.
// Optional FEEDER_CHECKSUM_EN adds a running sum of transferred words.
module glb_stream_feeder
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = PE_ADDR_WIDTH,
  parameter int unsigned PARA_WIDTH = PE_PARA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_start,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [PARA_WIDTH-1:0] cmd_len,
  output logic                  cmd_busy,
  output logic                  cmd_done,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  start_load,
  input  logic                  pe_fifo_full,
  output logic [DATA_WIDTH-1:0] data_out,
`ifdef FEEDER_CHECKSUM_EN
  output logic                  data_out_en,
  output logic [DATA_WIDTH+PARA_WIDTH-1:0] checksum
`else
  output logic                  data_out_en
`endif
);

  feeder_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [PARA_WIDTH-1:0] len_q;
  logic [PARA_WIDTH-1:0] issued_q;
  logic [PARA_WIDTH-1:0] xfer_q;
  logic                  inflight_q;

  logic                  buf_full, buf_empty;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [1:0]            occ;
  logic                  pop, rd_en, can_issue, accept, last_xfer;

  assign accept    = (state_q == ST_IDLE) && cmd_start;
  assign pop       = !buf_empty && !pe_fifo_full;
  assign occ       = buf_full ? 2'd2 : {1'b0, !buf_empty};
  assign last_xfer = (xfer_q == len_q - PARA_WIDTH'(1));
  // occupancy + inflight - pop < 2, rearranged to avoid unsigned underflow
  assign can_issue = (issued_q < len_q) &&
                     (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    start_load = 1'b0;
    cmd_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d = (cmd_len == '0) ? ST_DONE : ST_START;
        end
      end
      ST_START: begin
        start_load = 1'b1;
        rd_en      = can_issue;
        state_d    = ST_STREAM;
      end
      ST_STREAM: begin
        rd_en = can_issue;
        if (pop && last_xfer) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cmd_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      xfer_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      if (accept) begin
        addr_q   <= cmd_base_addr;
        len_q    <= cmd_len;
        issued_q <= '0;
        xfer_q   <= '0;
      end else begin
        if (rd_en) begin
          addr_q   <= addr_q + ADDR_WIDTH'(1);
          issued_q <= issued_q + PARA_WIDTH'(1);
        end
        if (pop) begin
          xfer_q <= xfer_q + PARA_WIDTH'(1);
        end
      end
    end
  end

  feeder_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data(ram_rd_data),
    .pop      (pop),
    .head     (buf_head),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  assign cmd_busy    = (state_q != ST_IDLE);
  assign ram_rd_en   = rd_en;
  assign ram_rd_addr = rd_en ? addr_q : '0;
  assign data_out    = buf_head;
  assign data_out_en = pop;

`ifdef FEEDER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + (DATA_WIDTH + PARA_WIDTH)'(buf_head);
    end
  end
`else
`endif

endmodule

// File: doc/glb_stream_feeder.md
GLB_STREAM_FEEDER -- requirements
Module: glb_stream_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the streamed word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning the global-buffer address width.
REQ-003 SHALL have parameter PARA_WIDTH, default 8, meaning the transfer-length width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cmd_start  in  1  one-cycle pulse that launches a transfer.
REQ-008 cmd_base_addr  in  ADDR_WIDTH  first RAM address, sampled with cmd_start.
REQ-009 cmd_len  in  PARA_WIDTH  word count, sampled with cmd_start.
REQ-010 cmd_busy  out  1  high from the cycle after an accepted cmd_start until cmd_done.
REQ-011 cmd_done  out  1  one-cycle completion pulse.
REQ-012 ram_rd_en  out  1  RAM read strobe.
REQ-013 ram_rd_addr  out  ADDR_WIDTH  RAM read address.
REQ-014 ram_rd_data  in  DATA_WIDTH  RAM data, valid exactly 1 cycle after ram_rd_en.
REQ-015 start_load  out  1  one-cycle pulse to PE start_feature_load/start_weight_load.
REQ-016 pe_fifo_full  in  1  PE input FIFO full (fifo_full_fmap/fifo_full_filter).
REQ-017 data_out  out  DATA_WIDTH  word to PE feature_in/weight_in.
REQ-018 data_out_en  out  1  transfer qualifier to PE feature_in_en/weight_in_en.

Function
REQ-019 SHALL implement FSM IDLE, START, STREAM, DONE.
- IDLE->START on cmd_start with cmd_len!=0.
- IDLE->DONE on cmd_start with cmd_len==0; no start_load, no reads.
- START->STREAM after 1 cycle.
- STREAM->DONE in the cycle after the last word is transferred.
- DONE->IDLE after 1 cycle.
REQ-020 SHALL assert start_load only in START and cmd_done only in DONE.
REQ-021 SHALL ignore cmd_start when not in IDLE.
REQ-022 SHALL issue reads in START and STREAM while issued<len and (occupancy+inflight-pop)<2, where occupancy = skid-buffer entries, inflight = reads awaiting data, and pop = current-cycle transfer.
REQ-023 SHALL increment ram_rd_addr modulo 2^ADDR_WIDTH, so 8'hFF wraps to 8'h00.
REQ-024 SHALL capture ram_rd_data into a 2-entry FIFO-ordered skid buffer one cycle after each ram_rd_en.
REQ-025 SHALL drive data_out_en = buffer_not_empty & !pe_fifo_full, combinationally; data_out is the buffer head.
REQ-026 SHALL count a word as transferred in every cycle in which data_out_en=1.
REQ-027 SHALL meet this latency with pe_fifo_full=0: cmd_start at cycle 0, start_load and first ram_rd_en at cycle 1, first data_out_en at cycle 3, then one word per cycle.
REQ-028 SHALL hold buffer contents unchanged while pe_fifo_full=1 and lose no words; the buffer never overflows.
REQ-029 SHALL drive data_out to the head value, or zero when empty; data_out_en=0 when empty.

Reset
REQ-030 SHALL, on rst, go to IDLE, clear the buffer, counters and inflight state, and drive all outputs to 0.
REQ-031 SHALL, on rst mid-transfer, abort without a cmd_done pulse; in-flight RAM data arriving next cycle is discarded.

Configuration
REQ-032 SHALL, with FEEDER_CHECKSUM_EN defined, add output checksum[DATA_WIDTH+PARA_WIDTH-1:0] = unsigned sum of the words transferred in the current or last command, cleared on accepted cmd_start and on rst.
REQ-033 SHALL, without FEEDER_CHECKSUM_EN, have no checksum port or logic.

Structure
REQ-034 SHALL place the FSM state encoding and the default widths (16/8/8) in a shared package, pe_pkg.
REQ-035 SHALL implement the skid buffer as sub-module feeder_skid_buf (2 entries, push/pop/full/empty).

Verification
REQ-036 base=0, len=6, RAM[i]=i+1, full=0 -> start_load at cycle 1; data_out 1..6 on cycles 3..8; cmd_done at cycle 9.
REQ-037 len=9, pe_fifo_full high on cycles 4-10 -> exactly 9 words in order, no duplicates; ram_rd_en never drives occupancy+inflight above 2.
REQ-038 base=8'hFE, len=4 -> ram_rd_addr FE, FF, 00, 01.
REQ-039 len=0 -> cmd_done the cycle after cmd_start; no start_load, ram_rd_en or data_out_en.
REQ-040 rst on cycle 5 of a len=10 transfer -> all outputs 0 the next cycle; no cmd_done; a new len=2 command then completes normally.
REQ-041 With FEEDER_CHECKSUM_EN, len=66 with data 37..102 -> checksum=4587; a second cmd_start mid-transfer is ignored.
